fft_frame_loader: RTL and testbench

Parametrised successor to the FFT input data generator. It captures one frame of 2^FRAME_LOG2 ADC samples into an internal buffer. It then streams the frame to the FFT core over an AXI4-Stream master port with full tready backpressure, and waits for the FFT result stream to finish before re-arming. It adds the following over the previous generation:
- generic sample/output widths and frame length
- offset-binary to two's-complement conversion
- single-shot and continuous capture modes
- sample-drop reporting
- optional DC removal

---
 rtl/fft_frame_loader.sv | 266 ++++++++++++++++++++++++++
 tb/tb_fft_frame_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_loader.sv
// fft_frame_loader
//
// Captures one frame of 2^FRAME_LOG2 ADC samples into an internal buffer, then streams it to
// an FFT core over an AXI4-Stream master with full tready backpressure, then waits for the
// falling edge of the FFT result tvalid before re-arming (continuous) or returning to idle
// (single-shot).
//
// Optional feature macro: FFT_DC_REMOVE_EN
//   When defined, the frame mean is accumulated during capture and subtracted from every
//   streamed beat. When undefined, beats carry the plain converted sample.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   mode           in   0 = continuous capture, 1 = single-shot (needs arm)
//   arm            in   one-cycle pulse; starts a capture in single-shot mode from idle
//   ad_valid       in   ad_data qualifier, one sample per asserted cycle
//   ad_data        in   ADC sample (offset-binary or two's complement, see SIGNED_IN)
//   fft_out_tvalid in   FFT result tvalid; its falling edge marks FFT done
//   m_axis_tdata   out  sign-extended (and optionally DC-removed) sample
//   m_axis_tvalid  out  beat valid
//   m_axis_tlast   out  asserted on the final beat of the frame
//   m_axis_tready  in   FFT core ready
//   cfg_tvalid     out  FFT config valid, tied low
//   busy           out  high in every state except idle
//   ad_drop        out  one-cycle pulse for each sample arriving outside capture
module fft_frame_loader #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FRAME_LOG2 = 8,
  parameter int unsigned OUT_W      = 16,
  parameter bit          SIGNED_IN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic              arm,
  input  logic              ad_valid,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              fft_out_tvalid,
  output logic [OUT_W-1:0]  m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic              cfg_tvalid,
  output logic              busy,
  output logic              ad_drop
);

  localparam int unsigned N   = 1 << FRAME_LOG2;
  localparam int unsigned ExtW = OUT_W - DATA_W;

  localparam logic [DATA_W-1:0]     MsbMask = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [FRAME_LOG2-1:0] LastIdx = '1;

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StStream,
    StWaitFft
  } state_e;

  state_e state_q, state_d;

  logic [FRAME_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  // One extra bit marks "all N reads issued".
  logic [FRAME_LOG2:0]   rd_cnt_q, rd_cnt_d;

  logic [DATA_W-1:0] mem_q [N];

  // Read stage: synchronous buffer output plus its valid/last tags.
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_vld_q, rd_vld_d;
  logic              rd_last_q;

  // Registered AXI-Stream output stage.
  logic [OUT_W-1:0]  tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;

  logic              drop_q, drop_d;
  logic              fft_tv_q;

  logic [DATA_W-1:0] conv_s;
  logic [OUT_W-1:0]  beat_value;
  logic              wr_en;
  logic              rd_en;
  logic              out_ready;
  logic              last_hs;
  logic              frame_end;
  logic              fft_fall;
  logic              enter_capture;

  // Offset-binary to two's complement is just an MSB flip.
  assign conv_s = SIGNED_IN ? ad_data : (ad_data ^ MsbMask);

  assign wr_en     = (state_q == StCapture) && ad_valid;
  assign frame_end = wr_en && (wr_ptr_q == LastIdx);
  assign out_ready = !tvalid_q || m_axis_tready;
  assign rd_en     = (state_q == StStream) && !rd_cnt_q[FRAME_LOG2] && (!rd_vld_q || out_ready);
  assign last_hs   = tvalid_q && m_axis_tready && tlast_q;
  assign fft_fall  = fft_tv_q && !fft_out_tvalid;

  assign enter_capture = (state_q != StCapture) && (state_d == StCapture);

  //---------------------------------------------------------------------------------------------
  // Main FSM and pointers
  //---------------------------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_cnt_d = rd_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (!mode || arm) begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + 1'b1;  // wraps to 0 after the final sample
          if (frame_end) begin
            state_d  = StStream;
            rd_cnt_d = '0;
          end
        end
      end
      StStream: begin
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (last_hs) begin
          state_d = StWaitFft;
        end
      end
      StWaitFft: begin
        if (fft_fall) begin
          state_d = mode ? StIdle : StCapture;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  //---------------------------------------------------------------------------------------------
  // Read and output pipeline
  //---------------------------------------------------------------------------------------------
  always_comb begin
    rd_vld_d = rd_vld_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    drop_d   = ad_valid && (state_q != StCapture);

    if (rd_en) begin
      rd_vld_d = 1'b1;
    end else if (out_ready) begin
      rd_vld_d = 1'b0;
    end

    // Output stage only moves when empty or its beat is being accepted, so data/last/valid
    // hold steady through any stall.
    if (out_ready) begin
      tvalid_d = rd_vld_q;
      tlast_d  = rd_vld_q && rd_last_q;
      if (rd_vld_q) begin
        tdata_d = beat_value;
      end
    end
  end

`ifdef FFT_DC_REMOVE_EN
  localparam int unsigned AccW = DATA_W + FRAME_LOG2;

  logic signed [AccW-1:0]   sum_q, sum_d;
  logic signed [AccW-1:0]   sum_next;
  logic signed [AccW-1:0]   acc_s;
  logic        [DATA_W-1:0] mean_q, mean_d;

  assign acc_s    = {{FRAME_LOG2{conv_s[DATA_W-1]}}, conv_s};
  assign sum_next = sum_q + acc_s;

  always_comb begin
    sum_d  = sum_q;
    mean_d = mean_q;
    if (enter_capture) begin
      sum_d = '0;
    end else if (wr_en) begin
      sum_d = sum_next;
    end
    // sum >>> FRAME_LOG2 truncated to DATA_W is exactly the top DATA_W bits of the sum.
    if (frame_end) begin
      mean_d = sum_next[FRAME_LOG2 +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      mean_q <= '0;
    end else begin
      sum_q  <= sum_d;
      mean_q <= mean_d;
    end
  end

  // Both operands fit DATA_W signed, so the difference fits OUT_W without saturation.
  assign beat_value = {{ExtW{rd_data_q[DATA_W-1]}}, rd_data_q}
                    - {{ExtW{mean_q[DATA_W-1]}}, mean_q};
`else
  logic unused_enter_capture;
  assign unused_enter_capture = enter_capture;
  assign beat_value = {{ExtW{rd_data_q[DATA_W-1]}}, rd_data_q};
`endif

  //---------------------------------------------------------------------------------------------
  // State registers
  //---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_cnt_q  <= '0;
      rd_vld_q  <= 1'b0;
      rd_last_q <= 1'b0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      tlast_q   <= 1'b0;
      drop_q    <= 1'b0;
      fft_tv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_vld_q  <= rd_vld_d;
      if (rd_en) begin
        rd_last_q <= (rd_cnt_q[FRAME_LOG2-1:0] == LastIdx);
      end
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      tlast_q   <= tlast_d;
      drop_q    <= drop_d;
      fft_tv_q  <= fft_out_tvalid;
    end
  end

  // Frame buffer: no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= conv_s;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_cnt_q[FRAME_LOG2-1:0]];
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign cfg_tvalid    = 1'b0;
  assign busy          = (state_q != StIdle);
  assign ad_drop       = drop_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
`timescale 1ns/1ps
module tb_fft_frame_loader;

  localparam int unsigned DataW     = 8;
  localparam int unsigned FrameLog2 = 8;
  localparam int unsigned OutW      = 16;
  localparam int unsigned N         = 256;

  logic             clk = 1'b0;
  logic             rst;
  logic             mode;
  logic             arm;
  logic             ad_valid;
  logic [DataW-1:0] ad_data;
  logic             fft_out_tvalid;
  logic [OutW-1:0]  m_axis_tdata;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;
  logic             cfg_tvalid;
  logic             busy;
  logic             ad_drop;

  fft_frame_loader #(
    .DATA_W     (DataW),
    .FRAME_LOG2 (FrameLog2),
    .OUT_W      (OutW),
    .SIGNED_IN  (1'b0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode           (mode),
    .arm            (arm),
    .ad_valid       (ad_valid),
    .ad_data        (ad_data),
    .fft_out_tvalid (fft_out_tvalid),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tready  (m_axis_tready),
    .cfg_tvalid     (cfg_tvalid),
    .busy           (busy),
    .ad_drop        (ad_drop)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OutW-1:0] data;
    logic            last;
  } beat_t;

  beat_t      exp_q[$];
  int         checks     = 0;
  int         failures   = 0;
  int         beats_seen = 0;
  int         drop_cnt   = 0;
  int         bp_base    = 0;
  int         bp_mode    = 0;
  logic [7:0] frame_data [N];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model: offset-binary -> signed, optional frame-mean subtraction.
  task automatic push_frame();
    int              mean;
    logic signed [7:0] s;
    beat_t           b;
    mean = 0;
`ifdef FFT_DC_REMOVE_EN
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < N; i++) begin
        s = frame_data[i] ^ 8'h80;
        sum += int'(s);
      end
      mean = sum >>> FrameLog2;
    end
`endif
    for (int i = 0; i < N; i++) begin
      s      = frame_data[i] ^ 8'h80;
      b.data = 16'(int'(s) - mean);
      b.last = (i == N - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_frame();
    push_frame();
    for (int i = 0; i < N; i++) begin
      ad_valid = 1'b1;
      ad_data  = frame_data[i];
      tick();
    end
    ad_valid = 1'b0;
  endtask

  task automatic send_samples(input int n);
    for (int i = 0; i < n; i++) begin
      ad_valid = 1'b1;
      ad_data  = 8'(8'h3C + i);
      tick();
    end
    ad_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int bound);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && k < bound) begin
      tick();
      k++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic fft_fall();
    fft_out_tvalid = 1'b1;
    tick();
    fft_out_tvalid = 1'b0;
    tick();
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic            prev_stall = 1'b0;
  logic [OutW-1:0] prev_data  = '0;
  logic            prev_last  = 1'b0;
  always @(negedge clk) begin
    if (ad_drop) drop_cnt++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_tvalid", int'(m_axis_tvalid), 1);
        check("stall_tdata", int'(m_axis_tdata), int'(prev_data));
        check("stall_tlast", int'(m_axis_tlast), int'(prev_last));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_axis_tdata);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("beat_tdata", int'(m_axis_tdata), int'(b.data));
          check("beat_tlast", int'(m_axis_tlast), int'(b.last));
        end
        beats_seen++;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
    end
  end

  // tready driver: 0 = always ready, 1 = toggle with a 10-cycle hold at beat 100, 3 = not ready.
  logic held = 1'b0;
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        1: begin
          if (!held && (beats_seen - bp_base == 100)) begin
            m_axis_tready = 1'b0;
            held          = 1'b1;
            repeat (9) begin
              @(posedge clk);
              #2;
            end
          end else begin
            m_axis_tready = ~m_axis_tready;
          end
        end
        3:       m_axis_tready = 1'b0;
        default: m_axis_tready = 1'b1;
      endcase
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int k;
    rst            = 1'b1;
    mode           = 1'b0;
    arm            = 1'b0;
    ad_valid       = 1'b0;
    ad_data        = '0;
    fft_out_tvalid = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_tvalid", int'(m_axis_tvalid), 0);
    check("rst_tlast", int'(m_axis_tlast), 0);
    check("rst_tdata", int'(m_axis_tdata), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_drop", int'(ad_drop), 0);
    check("rst_cfg", int'(cfg_tvalid), 0);
    rst = 1'b0;
    tick();
    check("t1_idle_to_capture", int'(busy), 1);

    // 1: continuous ramp, latency to first tvalid
    for (int i = 0; i < N; i++) frame_data[i] = 8'(i);
    d0 = drop_cnt;
    send_frame();
    check("t1_lat_k0", int'(m_axis_tvalid), 0);
    tick();
    check("t1_lat_k1", int'(m_axis_tvalid), 0);
    tick();
    check("t1_lat_k2", int'(m_axis_tvalid), 1);
`ifdef FFT_DC_REMOVE_EN
    check("t1_first_tdata", int'(m_axis_tdata), 'hFF81);
`else
    check("t1_first_tdata", int'(m_axis_tdata), 'hFF80);
`endif
    check("t1_no_drop", drop_cnt - d0, 0);
    wait_drain("t1", 2000);
    check("t1_wait_busy", int'(busy), 1);
    tick();
    check("t1_wait_tvalid", int'(m_axis_tvalid), 0);
    fft_fall();
    check("t1_rearm_busy", int'(busy), 1);

    // 2: backpressure
    for (int i = 0; i < N; i++) frame_data[i] = 8'(i * 37 + 11);
    bp_base = beats_seen;
    bp_mode = 1;
    send_frame();
    wait_drain("t2", 3000);
    bp_mode = 0;
    check("t2_beats", beats_seen - bp_base, 256);
    mode = 1'b1;
    fft_fall();
    check("t2_idle_busy", int'(busy), 0);

    // 3: single-shot, samples without arm are dropped
    d0 = drop_cnt;
    send_samples(5);
    tick();
    check("t3_idle_drops", drop_cnt - d0, 5);
    check("t3_idle_busy", int'(busy), 0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check("t3_arm_busy", int'(busy), 1);

    // 4: drops during STREAM and WAIT_FFT, no restart before the edge
    for (int i = 0; i < N; i++) frame_data[i] = 8'(255 - i);
    d0 = drop_cnt;
    send_frame();
    send_samples(3);
    wait_drain("t3", 2000);
    send_samples(2);
    tick();
    check("t4_drops", drop_cnt - d0, 5);
    repeat (5) tick();
    check("t4_still_wait", int'(busy), 1);
    check("t4_no_beat", int'(m_axis_tvalid), 0);
    fft_fall();
    check("t3_back_idle", int'(busy), 0);

    // 5: reset at beat 50
    mode = 1'b0;
    tick();
    for (int i = 0; i < N; i++) frame_data[i] = 8'(i) ^ 8'h55;
    bp_base = beats_seen;
    send_frame();
    k = 0;
    while (beats_seen - bp_base < 50 && k < 2000) begin
      tick();
      k++;
    end
    check("t5_reached_50", beats_seen - bp_base, 50);
    bp_mode = 3;
    rst     = 1'b1;
    tick();
    check("t5_rst_tvalid", int'(m_axis_tvalid), 0);
    check("t5_rst_tlast", int'(m_axis_tlast), 0);
    check("t5_rst_busy", int'(busy), 0);
    rst     = 1'b0;
    bp_mode = 0;
    exp_q.delete();
    tick();
    check("t5_recapture", int'(busy), 1);
    for (int i = 0; i < N; i++) frame_data[i] = 8'(i * 3);
    send_frame();
    wait_drain("t5", 2000);
    fft_fall();

    // 6: constant and alternating frames
    for (int i = 0; i < N; i++) frame_data[i] = 8'hA0;
    send_frame();
    tick();
    tick();
`ifdef FFT_DC_REMOVE_EN
    check("t6_const_first", int'(m_axis_tdata), 'h0000);
`else
    check("t6_const_first", int'(m_axis_tdata), 'h0020);
`endif
    wait_drain("t6a", 2000);
    fft_fall();
    for (int i = 0; i < N; i++) frame_data[i] = (i % 2 == 0) ? 8'h90 : 8'h70;
    send_frame();
    tick();
    tick();
    check("t6_alt_first", int'(m_axis_tdata), 'h0010);
    wait_drain("t6b", 2000);
    mode = 1'b1;
    fft_fall();
    check("t6_end_idle", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
